// File: rtl/lab3_sys_button_pio_if.sv
// Avalon-MM slave bus bundle for the button PIO: word address, select, write strobe and data.
interface lab3_sys_button_pio_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/lab3_sys_button_pio.sv
// Button/switch PIO: synchronised input data, per-bit edge capture with W1C and masked level irq.
module lab3_sys_button_pio #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned EDGE_TYPE = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  lab3_sys_button_pio_if.slave  bus,
  input  logic [WIDTH-1:0]      in_port,
  output logic                  irq
);

  logic [WIDTH-1:0] sync1_q, sync2_q, sync_dly_q;
  logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
  logic [WIDTH-1:0] edge_cap_q, edge_cap_d;
  logic [WIDTH-1:0] edge_det;
  logic             wr_en;

  // Upper write-data bits beyond WIDTH have no destination.
  logic unused_wdata;
  assign unused_wdata = ^bus.writedata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      sync_dly_q <= '0;
      irq_mask_q <= '0;
      edge_cap_q <= '0;
    end else begin
      sync1_q    <= in_port;
      sync2_q    <= sync1_q;
      sync_dly_q <= sync2_q;
      irq_mask_q <= irq_mask_d;
      edge_cap_q <= edge_cap_d;
    end
  end

  always_comb begin
    if (EDGE_TYPE == 0) begin
      edge_det = sync2_q & ~sync_dly_q;
    end else if (EDGE_TYPE == 1) begin
      edge_det = ~sync2_q & sync_dly_q;
    end else begin
      edge_det = sync2_q ^ sync_dly_q;
    end
  end

  assign wr_en = bus.chipselect & ~bus.write_n;

  always_comb begin
    irq_mask_d = irq_mask_q;
    edge_cap_d = edge_cap_q;
    if (wr_en && (bus.address == 2'd2)) begin
      irq_mask_d = bus.writedata[WIDTH-1:0];
    end
    if (wr_en && (bus.address == 2'd3)) begin
      edge_cap_d = edge_cap_q & ~bus.writedata[WIDTH-1:0];
    end
    // A fresh edge overrides a coincident clear.
    edge_cap_d = edge_cap_d | edge_det;
  end

  always_comb begin
    bus.readdata = '0;
    unique case (bus.address)
      2'd0:    bus.readdata = 32'(sync2_q);
      2'd1:    bus.readdata = '0;
      2'd2:    bus.readdata = 32'(irq_mask_q);
      2'd3:    bus.readdata = 32'(edge_cap_q);
      default: bus.readdata = '0;
    endcase
  end

  assign irq = |(edge_cap_q & irq_mask_q);

endmodule

// File: doc/lab3_sys_button_pio.md
LAB3_SYS_BUTTON_PIO -- requirements
Module: lab3_sys_button_pio

Interface
REQ-001 SHALL have parameter WIDTH, default 4, number of input bits (1..32).
REQ-002 SHALL have parameter EDGE_TYPE, default 0: 0 = rising, 1 = falling, 2 = any edge.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port address  input  2  Avalon-MM slave word address.
REQ-006 SHALL have port chipselect  input  1  slave select.
REQ-007 SHALL have port write_n  input  1  write strobe, active-low.
REQ-008 SHALL have port writedata  input  32  write data.
REQ-009 SHALL have port in_port  input  WIDTH  asynchronous external inputs (buttons/switches).
REQ-010 SHALL have port readdata  output  32  read data, zero-wait-state.
REQ-011 SHALL have port irq  output  1  level interrupt, active-high.

Function
REQ-012 SHALL pass in_port through a two-flop synchronizer (sync1, sync2) plus one delay flop (sync_d) per bit.
REQ-013 SHALL detect per-bit edges combinationally: rising = sync2 & ~sync_d; falling = ~sync2 & sync_d; any = sync2 ^ sync_d; selected by EDGE_TYPE.
REQ-014 SHALL provide register map: addr 0 DATA (RO, = sync2); addr 1 reserved (reads 0); addr 2 IRQMASK (RW, WIDTH bits); addr 3 EDGECAP (R, write-1-to-clear per bit).
REQ-015 SHALL drive readdata combinationally from address and current register values, upper 32-WIDTH bits zero, value independent of chipselect/write_n.
REQ-016 SHALL accept a write when chipselect=1 and write_n=0; writes to addr 0 and 1 have no effect.
REQ-017 SHALL load IRQMASK <= writedata[WIDTH-1:0] on an accepted write to addr 2.
REQ-018 SHALL set an EDGECAP bit on the clock edge after its edge is detected, and hold it until cleared.
REQ-019 SHALL clear EDGECAP bit i on an accepted write to addr 3 with writedata[i]=1; bits with writedata[i]=0 unchanged.
REQ-020 SHALL give set priority over clear when detection and clear of the same bit coincide in one cycle (bit remains 1).
REQ-021 SHALL drive irq = OR over i of (EDGECAP[i] & IRQMASK[i]), combinational from registers.
REQ-022 SHALL have latency: in_port change setup before edge E0 -> sync1 after E0 -> DATA reads new value after E1 -> EDGECAP set and irq high after E2.
REQ-023 SHALL ignore input pulses shorter than one clock period only insofar as the synchronizer misses them; no debouncing is performed.
REQ-024 SHALL deassert irq in the cycle after the clearing write (or mask write) takes effect.

Reset
REQ-025 SHALL, while reset_n=0, asynchronously force sync1, sync2, sync_d, IRQMASK, EDGECAP to 0; hence readdata for addr 0/2/3 = 0 and irq = 0.
REQ-026 SHALL, after reset release with in_port already high and EDGE_TYPE=0, capture a rising edge on every high bit (sync registers start at 0).
REQ-027 SHALL, on reset asserted mid-operation, discard pending edges and mask with no spurious irq after release except per REQ-026.

Verification
REQ-028 Reset, in_port=4'b0000, read addr 0/2/3 -> 0x0, irq=0.
REQ-029 IRQMASK=0x1, in_port 0->4'b0001 before E0 -> addr0 reads 0x1 after E1, addr3 reads 0x1 and irq=1 after E2; write 0x1 to addr3 -> addr3=0x0, irq=0 next cycle.
REQ-030 IRQMASK=0x0, rising edge on bit 2 -> EDGECAP=0x4, irq=0; then write 0x4 to addr2 -> irq=1 next cycle.
REQ-031 EDGECAP=0x3, write 0x1 to addr3 -> EDGECAP=0x2 (only bit 0 cleared).
REQ-032 Clear write to addr3 (0x1) in the same cycle bit-0 edge is detected -> EDGECAP bit 0 stays 1.
REQ-033 EDGE_TYPE=1, in_port 0x1->0x0 -> EDGECAP=0x1; EDGE_TYPE=2, in_port toggles bit 3 twice with clear between -> bit 3 captured each time.
